ddl_event_scheduler: RTL and testbench
======================================

DDL_EVENT_SCHEDULER -- requirements
Module: ddl_event_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd40000, max cycles to wait for unmasked DTCs after collection starts.
REQ-002 SHALL have parameter PEND_DEPTH, default 4'd4, number of accepted events the DTC RAMs buffer.
REQ-003 SHALL have a single clock and a synchronous, active-high reset: siu_foCLK  in  1  only clock; siu_reset  in  1  reset.
REQ-004 SHALL have port EventValid  in  1  one-cycle pulse, one trigger accepted.
REQ-005 SHALL have port DtcEventDone  in  20  per-DTC pulse, event fully written to its RAM.
REQ-006 SHALL have port rdo_cfg  in  60  readout config; bits [19:0] are the DTC mask, 1 = DTC skipped.
REQ-007 SHALL have port ddl_tx_start  in  1  high while the DDL interface transmits an event (CDH through gap).
REQ-008 SHALL have port DtcRamReadConfirm  in  1  high while the DDL interface reads DTC RAMs.
REQ-009 SHALL have port EventRdySent  out  1  request to the DDL interface to send one event.
REQ-010 SHALL have port STrigErrFlag  out  1  current event timed out; DDL interface sends trailer only.
REQ-011 SHALL have port DtcTimeoutMap  out  20  unmasked DTCs not done at timeout, held for the current event.
REQ-012 SHALL have port DtcRamRelease  out  1  one-cycle pulse, one RAM event slot freed.
REQ-013 SHALL have port pend_cnt  out  4  accepted events not yet released.
REQ-014 SHALL have port pend_full  out  1  pend_cnt == PEND_DEPTH.
REQ-015 SHALL have port pend_ovf  out  1  sticky, EventValid seen while full.
REQ-016 SHALL have port sched_st  out  5  one-hot state, debug.

Function
REQ-017 SHALL implement states IDLE, COLLECT, ISSUE, SENDING, RELEASE (one-hot, in that bit order LSB first).
REQ-018 SHALL go IDLE->COLLECT when pend_cnt != 0, latching req_map = ~rdo_cfg[19:0] and clearing the timeout counter.
REQ-019 SHALL keep a sticky done_map: bit i set on DtcEventDone[i] in any state, cleared only in RELEASE.
REQ-020 SHALL go COLLECT->ISSUE when (done_map & req_map) == req_map, including req_map == 0, with STrigErrFlag = 0.
REQ-021 SHALL go COLLECT->ISSUE on timeout counter == TIMEOUT_CYCLES-1, setting STrigErrFlag = 1 and DtcTimeoutMap = req_map & ~done_map.
REQ-022 SHALL give completion priority over timeout when both occur in the same cycle.
REQ-023 SHALL assert EventRdySent registered in ISSUE and hold it until ddl_tx_start == 1, then deassert it and go to SENDING.
REQ-024 SHALL go SENDING->RELEASE when ddl_tx_start == 0 and DtcRamReadConfirm == 0.
REQ-025 SHALL pulse DtcRamRelease in RELEASE, clear done_map and STrigErrFlag, and return to IDLE.
REQ-026 SHALL hold DtcTimeoutMap until the next COLLECT entry.
REQ-027 SHALL increment pend_cnt on EventValid unless full.
REQ-028 SHALL decrement pend_cnt on DtcRamRelease.
REQ-029 SHALL leave pend_cnt unchanged when EventValid and DtcRamRelease coincide, including when full.
REQ-030 SHALL ignore EventValid while full, set pend_ovf, and never let pend_cnt wrap.
REQ-031 SHALL keep the timeout counter at 16 bits, saturating, counting only in COLLECT.
REQ-032 SHALL treat DtcEventDone on masked DTCs as recorded but irrelevant to completion.

Reset
REQ-033 SHALL on siu_reset, at any state including mid-transmission, set state IDLE, EventRdySent 0, STrigErrFlag 0, DtcTimeoutMap 0, DtcRamRelease 0, pend_cnt 0, pend_full 0, pend_ovf 0, done_map 0, timer 0, sched_st 5'b00001.
REQ-034 SHALL leave all outputs at reset values in the first cycle after reset deasserts.

Structure
REQ-035 SHALL take state encodings, NUM_DTC = 20 and the mask bit range from the shared SRU package.
REQ-036 SHALL implement the pend_cnt up/down counter as sub-module sru_event_credit_cnt.

Verification
REQ-037 SHALL verify: EventValid, all 20 DTCs masked except 0 and 5, pulse done 0 then 5 -> ISSUE one cycle after the second pulse, EventRdySent high until ddl_tx_start, one DtcRamRelease, pend_cnt 1->0.
REQ-038 SHALL verify: TIMEOUT_CYCLES = 100, mask 0, only DTC 3 done -> STrigErrFlag = 1 and DtcTimeoutMap = 20'hFFFF7 at cycle 100 of COLLECT.
REQ-039 SHALL verify: 5 EventValid pulses with no release -> pend_cnt 4, pend_full 1, pend_ovf 1.
REQ-040 SHALL verify: EventValid coincident with DtcRamRelease at pend_cnt 4 -> pend_cnt stays 4.
REQ-041 SHALL verify: siu_reset while EventRdySent high and ddl_tx_start high -> next cycle all outputs at reset values, no DtcRamRelease.
REQ-042 SHALL verify: rdo_cfg[19:0] = 20'hFFFFF -> ISSUE one cycle after COLLECT entry, STrigErrFlag 0.

Source files
------------

// File: rtl/ddl_event_scheduler_pkg.sv
// ddl_event_scheduler_pkg: shared SRU constants, scheduler state encodings and DTC map type.
package ddl_event_scheduler_pkg;
    localparam int NUM_DTC  = 20;
    localparam int MASK_LSB = 0;
    localparam int MASK_MSB = NUM_DTC - 1;
    localparam int CFG_W    = 60;
    localparam logic [4:0] ST_IDLE    = 5'b00001;
    localparam logic [4:0] ST_COLLECT = 5'b00010;
    localparam logic [4:0] ST_ISSUE   = 5'b00100;
    localparam logic [4:0] ST_SENDING = 5'b01000;
    localparam logic [4:0] ST_RELEASE = 5'b10000;
    typedef logic [NUM_DTC-1:0] dtc_map_t;
endpackage

// File: rtl/ddl_event_scheduler_if.sv
// ddl_event_scheduler_if: trigger, DTC, DDL handshake and status signals of the event scheduler.
interface ddl_event_scheduler_if;
    logic EventValid;
    ddl_event_scheduler_pkg::dtc_map_t DtcEventDone;
    logic [ddl_event_scheduler_pkg::CFG_W-1:0] rdo_cfg;
    logic ddl_tx_start;
    logic DtcRamReadConfirm;
    logic EventRdySent;
    logic STrigErrFlag;
    ddl_event_scheduler_pkg::dtc_map_t DtcTimeoutMap;
    logic DtcRamRelease;
    logic [3:0] pend_cnt;
    logic pend_full;
    logic pend_ovf;
    logic [4:0] sched_st;
    modport slave (
        input  EventValid, DtcEventDone, rdo_cfg, ddl_tx_start, DtcRamReadConfirm,
        output EventRdySent, STrigErrFlag, DtcTimeoutMap, DtcRamRelease,
        output pend_cnt, pend_full, pend_ovf, sched_st
    );
    modport master (
        output EventValid, DtcEventDone, rdo_cfg, ddl_tx_start, DtcRamReadConfirm,
        input  EventRdySent, STrigErrFlag, DtcTimeoutMap, DtcRamRelease,
        input  pend_cnt, pend_full, pend_ovf, sched_st
    );
endinterface

// File: rtl/sru_event_credit_cnt.sv
// sru_event_credit_cnt: saturating count of accepted-but-unreleased events with sticky overflow.
module sru_event_credit_cnt #(
    parameter logic [3:0] DEPTH = 4'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] cnt,
    output logic       full,
    output logic       ovf
);
    assign full = cnt == DEPTH;
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            cnt <= (inc && dec) ? cnt :
                   dec ? cnt - 4'(cnt != 4'd0) :
                   (inc && !full) ? cnt + 4'd1 : cnt;
            ovf <= ovf | (inc & full);
        end
    end
endmodule

// File: rtl/ddl_event_scheduler.sv
// ddl_event_scheduler: waits for unmasked DTCs (or timeout), hands one event to the DDL
// interface, then frees its RAM slot.
module ddl_event_scheduler
    import ddl_event_scheduler_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd40000,
    parameter logic [3:0]  PEND_DEPTH     = 4'd4
) (
    input logic siu_foCLK,
    input logic siu_reset,
    ddl_event_scheduler_if.slave bus
);
    logic [4:0]  state;
    dtc_map_t    req_map, done_map, done_nxt, tmap;
    logic [15:0] timer;
    logic        rdy, err, complete, timeout, unused_cfg;
    // A done pulse arriving this cycle already counts towards completion.
    assign done_nxt          = done_map | bus.DtcEventDone;
    assign complete          = (done_nxt & req_map) == req_map;
    assign timeout           = timer == TIMEOUT_CYCLES - 16'd1;
    assign bus.sched_st      = state;
    assign bus.DtcRamRelease = state == ST_RELEASE;
    assign bus.EventRdySent  = rdy;
    assign bus.STrigErrFlag  = err;
    assign bus.DtcTimeoutMap = tmap;
    assign unused_cfg        = ^bus.rdo_cfg[CFG_W-1:MASK_MSB+1];
    always_ff @(posedge siu_foCLK) begin
        if (siu_reset) begin
            state    <= ST_IDLE;
            req_map  <= '0;
            done_map <= '0;
            timer    <= '0;
            rdy      <= 1'b0;
            err      <= 1'b0;
            tmap     <= '0;
        end else begin
            done_map <= (state == ST_RELEASE) ? bus.DtcEventDone : done_nxt;
            timer    <= (state == ST_COLLECT && timer != 16'hFFFF) ? timer + 16'd1 : timer;
            case (state)
                ST_IDLE: if (bus.pend_cnt != 4'd0) begin
                    state   <= ST_COLLECT;
                    req_map <= ~bus.rdo_cfg[MASK_MSB:MASK_LSB];
                    timer   <= '0;
                    tmap    <= '0;
                end
                ST_COLLECT: if (complete || timeout) begin
                    state <= ST_ISSUE;
                    rdy   <= 1'b1;
                    err   <= !complete;
                    tmap  <= complete ? tmap : req_map & ~done_map;
                end
                ST_ISSUE: if (bus.ddl_tx_start) begin
                    state <= ST_SENDING;
                    rdy   <= 1'b0;
                end
                ST_SENDING: if (!bus.ddl_tx_start && !bus.DtcRamReadConfirm) state <= ST_RELEASE;
                ST_RELEASE: begin
                    state <= ST_IDLE;
                    err   <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
    sru_event_credit_cnt #(.DEPTH(PEND_DEPTH)) u_credit (
        .clk  (siu_foCLK),
        .rst  (siu_reset),
        .inc  (bus.EventValid),
        .dec  (bus.DtcRamRelease),
        .cnt  (bus.pend_cnt),
        .full (bus.pend_full),
        .ovf  (bus.pend_ovf)
    );
endmodule

// File: tb/tb_ddl_event_scheduler.sv
// tb_ddl_event_scheduler: directed stimulus with issue/release scoreboards checked by a negedge monitor.
module tb_ddl_event_scheduler;
    import ddl_event_scheduler_pkg::*;
    typedef struct {logic err; logic [19:0] map; int lat;} iss_t;
    typedef struct {int pre; int post;} rel_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0, errors = 0, ccnt = 0, rel_seen = 0, rel_post = 0;
    logic prev_rdy = 1'b0, rel_chk = 1'b0;
    iss_t iq[$];
    rel_t rq[$];
    iss_t ie;
    rel_t re;
    ddl_event_scheduler_if bus();
    ddl_event_scheduler #(.TIMEOUT_CYCLES(16'd100), .PEND_DEPTH(4'd4)) dut (
        .siu_foCLK (clk),
        .siu_reset (rst),
        .bus       (bus.slave)
    );
    always #5 clk = ~clk;
    task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
        vectors++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask
    // Monitor: pops expectations when the DUT raises EventRdySent or DtcRamRelease.
    always @(negedge clk) begin
        if (rel_chk) begin
            check("rel_width", 32'(bus.DtcRamRelease), 0);
            check("rel_post_cnt", 32'(bus.pend_cnt), rel_post);
            rel_chk = 1'b0;
        end
        if (bus.DtcRamRelease === 1'b1) begin
            rel_seen++;
            if (rq.size() == 0) check("rel_unexpected", 1, 0);
            else begin
                re = rq.pop_front();
                check("rel_pre_cnt", 32'(bus.pend_cnt), re.pre);
                rel_post = re.post;
                rel_chk = 1'b1;
            end
        end
        if (bus.EventRdySent === 1'b1 && !prev_rdy) begin
            if (iq.size() == 0) check("issue_unexpected", 1, 0);
            else begin
                ie = iq.pop_front();
                check("issue_state", 32'(bus.sched_st), 32'(ST_ISSUE));
                check("issue_err", 32'(bus.STrigErrFlag), 32'(ie.err));
                check("issue_map", 32'(bus.DtcTimeoutMap), 32'(ie.map));
                if (ie.lat >= 0) check("issue_latency", ccnt, ie.lat);
            end
        end
        prev_rdy = bus.EventRdySent === 1'b1;
        ccnt = (bus.sched_st == ST_COLLECT) ? ccnt + 1 : (bus.sched_st == ST_IDLE) ? 0 : ccnt;
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic push_iss(input logic err, input logic [19:0] map, input int lat);
        iss_t x;
        x.err = err;
        x.map = map;
        x.lat = lat;
        iq.push_back(x);
    endtask
    task automatic push_rel(input int pre, input int post);
        rel_t x;
        x.pre = pre;
        x.post = post;
        rq.push_back(x);
    endtask
    task automatic pulse_ev();
        bus.EventValid = 1'b1;
        tick();
        bus.EventValid = 1'b0;
    endtask
    task automatic wait_st(input logic [4:0] s, input int budget, input string n);
        int k = 0;
        while (bus.sched_st !== s && k < budget) begin
            tick();
            k++;
        end
        check(n, 32'(bus.sched_st), 32'(s));
    endtask
    task automatic check_reset(input string n);
        check({n, "_st"}, 32'(bus.sched_st), 32'(5'b00001));
        check({n, "_rdy"}, 32'(bus.EventRdySent), 0);
        check({n, "_err"}, 32'(bus.STrigErrFlag), 0);
        check({n, "_map"}, 32'(bus.DtcTimeoutMap), 0);
        check({n, "_rel"}, 32'(bus.DtcRamRelease), 0);
        check({n, "_cnt"}, 32'(bus.pend_cnt), 0);
        check({n, "_full"}, 32'(bus.pend_full), 0);
        check({n, "_ovf"}, 32'(bus.pend_ovf), 0);
    endtask
    task automatic handshake(input logic ev_rel);
        int k = 0;
        while (bus.EventRdySent !== 1'b1 && k < 300) begin
            tick();
            k++;
        end
        check("rdy_wait", 32'(bus.EventRdySent), 1);
        tick();
        check("rdy_hold", 32'(bus.EventRdySent), 1);
        bus.ddl_tx_start = 1'b1;
        bus.DtcRamReadConfirm = 1'b1;
        tick();
        check("rdy_drop", 32'(bus.EventRdySent), 0);
        check("sending", 32'(bus.sched_st), 32'(ST_SENDING));
        tick();
        bus.ddl_tx_start = 1'b0;
        tick();
        check("hold_on_confirm", 32'(bus.sched_st), 32'(ST_SENDING));
        bus.DtcRamReadConfirm = 1'b0;
        tick();
        check("release_state", 32'(bus.sched_st), 32'(ST_RELEASE));
        bus.EventValid = ev_rel;
        tick();
        bus.EventValid = 1'b0;
        check("back_idle", 32'(bus.sched_st), 32'(ST_IDLE));
    endtask
    initial begin
        int rs;
        bus.EventValid = 1'b0;
        bus.DtcEventDone = '0;
        bus.rdo_cfg = '0;
        bus.ddl_tx_start = 1'b0;
        bus.DtcRamReadConfirm = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check_reset("por");
        tick();
        check_reset("por_idle");
        // Only DTCs 0 and 5 required; upper config bits must be ignored.
        bus.rdo_cfg = {40'hA5A5A5A5A5, 20'hFFFDE};
        push_iss(1'b0, 20'h0, 3);
        push_rel(1, 0);
        pulse_ev();
        check("pend_inc", 32'(bus.pend_cnt), 1);
        wait_st(ST_COLLECT, 10, "enter_collect");
        bus.DtcEventDone = 20'h00001;
        tick();
        bus.DtcEventDone = '0;
        tick();
        check("wait_dtc5", 32'(bus.sched_st), 32'(ST_COLLECT));
        bus.DtcEventDone = 20'h00020;
        tick();
        bus.DtcEventDone = '0;
        check("issue_after_dtc5", 32'(bus.sched_st), 32'(ST_ISSUE));
        handshake(1'b0);
        check("pend_after_rel", 32'(bus.pend_cnt), 0);
        // Timeout: all DTCs required, only DTC 3 reports.
        bus.rdo_cfg = '0;
        push_iss(1'b1, 20'hFFFF7, 100);
        push_rel(1, 0);
        pulse_ev();
        wait_st(ST_COLLECT, 10, "enter_collect_to");
        bus.DtcEventDone = 20'h00008;
        tick();
        bus.DtcEventDone = '0;
        handshake(1'b0);
        check("err_cleared", 32'(bus.STrigErrFlag), 0);
        check("map_held", 32'(bus.DtcTimeoutMap), 32'h000FFFF7);
        // Everything masked: immediate issue, timeout map cleared at entry.
        bus.rdo_cfg = {40'h0, 20'hFFFFF};
        push_iss(1'b0, 20'h0, 1);
        push_rel(1, 0);
        pulse_ev();
        wait_st(ST_COLLECT, 10, "enter_collect_all");
        tick();
        check("issue_all_masked", 32'(bus.sched_st), 32'(ST_ISSUE));
        check("err_all_masked", 32'(bus.STrigErrFlag), 0);
        handshake(1'b0);
        // Overflow, then EventValid coincident with release while full.
        bus.rdo_cfg = '0;
        push_iss(1'b0, 20'h0, -1);
        bus.EventValid = 1'b1;
        repeat (5) tick();
        bus.EventValid = 1'b0;
        check("ovf_cnt", 32'(bus.pend_cnt), 4);
        check("ovf_full", 32'(bus.pend_full), 1);
        check("ovf_flag", 32'(bus.pend_ovf), 1);
        bus.DtcEventDone = '1;
        tick();
        bus.DtcEventDone = '0;
        push_rel(4, 4);
        handshake(1'b1);
        check("coincide_cnt", 32'(bus.pend_cnt), 4);
        check("coincide_full", 32'(bus.pend_full), 1);
        // Reset in the middle of the ISSUE/tx_start handshake.
        push_iss(1'b0, 20'h0, -1);
        wait_st(ST_COLLECT, 10, "enter_collect_rst");
        bus.DtcEventDone = '1;
        tick();
        bus.DtcEventDone = '0;
        check("rdy_before_rst", 32'(bus.EventRdySent), 1);
        rs = rel_seen;
        bus.ddl_tx_start = 1'b1;
        rst = 1'b1;
        tick();
        check_reset("mid_tx");
        rst = 1'b0;
        bus.ddl_tx_start = 1'b0;
        tick();
        check_reset("post_rst");
        repeat (3) tick();
        check("no_release_after_rst", rel_seen, rs);
        check("iq_drained", iq.size(), 0);
        check("rq_drained", rq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
